// File: rtl/hyper_macro_cfg_resp.sv
// Register-mapped configuration port for one RX and one TX channel.
// Two-state handshake: accept in IDLE, respond one cycle later in RESP.
module hyper_macro_cfg_resp #(
    parameter int          AW     = 19,
    parameter int          TS     = 20,
    parameter logic [31:0] ID_VAL = 32'h4859_0001
) (
    input  logic          sys_clk_i,
    input  logic          rst_i,
    input  logic [31:0]   cfg_data_i,
    input  logic [5:0]    cfg_addr_i,
    input  logic          cfg_valid_i,
    input  logic          cfg_rwn_i,
    output logic          cfg_ready_o,
    output logic [31:0]   cfg_data_o,
    output logic [AW-1:0] rx_startaddr_o,
    output logic [TS-1:0] rx_size_o,
    output logic [1:0]    rx_datasize_o,
    output logic          rx_continuous_o,
    output logic          rx_req_o,
    output logic          rx_clr_o,
    input  logic          rx_en_i,
    input  logic          rx_pending_i,
    input  logic [AW-1:0] rx_curr_addr_i,
    input  logic [TS-1:0] rx_bytes_left_i,
    output logic [AW-1:0] tx_startaddr_o,
    output logic [TS-1:0] tx_size_o,
    output logic [1:0]    tx_datasize_o,
    output logic          tx_continuous_o,
    output logic          tx_req_o,
    output logic          tx_clr_o,
    input  logic          tx_en_i,
    input  logic          tx_pending_i,
    input  logic [AW-1:0] tx_curr_addr_i,
    input  logic [TS-1:0] tx_bytes_left_i
);

    typedef enum logic {IDLE, RESP} state_t;

    localparam logic [5:0] A_RX_SADDR = 6'h00;
    localparam logic [5:0] A_RX_SIZE  = 6'h01;
    localparam logic [5:0] A_RX_CFG   = 6'h02;
    localparam logic [5:0] A_TX_SADDR = 6'h04;
    localparam logic [5:0] A_TX_SIZE  = 6'h05;
    localparam logic [5:0] A_TX_CFG   = 6'h06;
    localparam logic [5:0] A_ID       = 6'h20;
    localparam logic [5:0] A_SCRATCH  = 6'h21;

    state_t        state_q, state_d;
    logic [5:0]    addr_q;
    logic [31:0]   wdata_q;
    logic          rwn_q;
    logic [31:0]   rdata_q;
    logic [31:0]   rd_mux;
    logic [31:0]   scratch_q;
    logic          accept;
    logic          wr_en;
    logic          wr_rx_cfg, wr_tx_cfg;
    logic          rx_req_d, rx_clr_d, tx_req_d, tx_clr_d;
    logic          rx_req_q, rx_clr_q, tx_req_q, tx_clr_q;

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (cfg_valid_i) state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign accept = (state_q == IDLE) && cfg_valid_i;
    assign wr_en  = (state_q == RESP) && !rwn_q;

    // Status inputs are sampled at acceptance; the response shows that snapshot.
    always_comb begin
        rd_mux = '0;
        case (cfg_addr_i)
            A_RX_SADDR: rd_mux = {{(32-AW){1'b0}}, rx_curr_addr_i};
            A_RX_SIZE:  rd_mux = {{(32-TS){1'b0}}, rx_bytes_left_i};
            A_RX_CFG:   rd_mux = {26'd0, rx_pending_i, rx_en_i, 1'b0,
                                  rx_datasize_o, rx_continuous_o};
            A_TX_SADDR: rd_mux = {{(32-AW){1'b0}}, tx_curr_addr_i};
            A_TX_SIZE:  rd_mux = {{(32-TS){1'b0}}, tx_bytes_left_i};
            A_TX_CFG:   rd_mux = {26'd0, tx_pending_i, tx_en_i, 1'b0,
                                  tx_datasize_o, tx_continuous_o};
            A_ID:       rd_mux = ID_VAL;
            A_SCRATCH:  rd_mux = scratch_q;
            default:    rd_mux = '0;
        endcase
    end

    assign wr_rx_cfg = wr_en && (addr_q == A_RX_CFG);
    assign wr_tx_cfg = wr_en && (addr_q == A_TX_CFG);

    // CLR wins over EN; a start on a busy channel with a pending slot is dropped.
    assign rx_clr_d = wr_rx_cfg && wdata_q[6];
    assign rx_req_d = wr_rx_cfg && wdata_q[4] && !wdata_q[6]
                      && !(rx_en_i && rx_pending_i);
    assign tx_clr_d = wr_tx_cfg && wdata_q[6];
    assign tx_req_d = wr_tx_cfg && wdata_q[4] && !wdata_q[6]
                      && !(tx_en_i && tx_pending_i);

    always_ff @(posedge sys_clk_i) begin
        if (rst_i) begin
            state_q         <= IDLE;
            addr_q          <= '0;
            wdata_q         <= '0;
            rwn_q           <= 1'b0;
            rdata_q         <= '0;
            scratch_q       <= '0;
            rx_startaddr_o  <= '0;
            rx_size_o       <= '0;
            rx_datasize_o   <= '0;
            rx_continuous_o <= 1'b0;
            tx_startaddr_o  <= '0;
            tx_size_o       <= '0;
            tx_datasize_o   <= '0;
            tx_continuous_o <= 1'b0;
            rx_req_q        <= 1'b0;
            rx_clr_q        <= 1'b0;
            tx_req_q        <= 1'b0;
            tx_clr_q        <= 1'b0;
        end else begin
            state_q  <= state_d;
            rdata_q  <= (accept && cfg_rwn_i) ? rd_mux : '0;
            rx_req_q <= rx_req_d;
            rx_clr_q <= rx_clr_d;
            tx_req_q <= tx_req_d;
            tx_clr_q <= tx_clr_d;
            if (accept) begin
                addr_q  <= cfg_addr_i;
                wdata_q <= cfg_data_i;
                rwn_q   <= cfg_rwn_i;
            end
            if (wr_en) begin
                case (addr_q)
                    A_RX_SADDR: rx_startaddr_o <= wdata_q[AW-1:0];
                    A_RX_SIZE:  rx_size_o      <= wdata_q[TS-1:0];
                    A_RX_CFG: begin
                        rx_continuous_o <= wdata_q[0];
                        rx_datasize_o   <= wdata_q[2:1];
                    end
                    A_TX_SADDR: tx_startaddr_o <= wdata_q[AW-1:0];
                    A_TX_SIZE:  tx_size_o      <= wdata_q[TS-1:0];
                    A_TX_CFG: begin
                        tx_continuous_o <= wdata_q[0];
                        tx_datasize_o   <= wdata_q[2:1];
                    end
                    A_SCRATCH:  scratch_q <= wdata_q;
                    default: ;
                endcase
            end
        end
    end

    assign cfg_ready_o = (state_q == RESP);
    assign cfg_data_o  = rdata_q;
    assign rx_req_o    = rx_req_q;
    assign rx_clr_o    = rx_clr_q;
    assign tx_req_o    = tx_req_q;
    assign tx_clr_o    = tx_clr_q;

endmodule

// File: tb/tb_hyper_macro_cfg_resp.sv
// Scoreboard bench for hyper_macro_cfg_resp: directed scenarios plus
// randomized traffic checked against a register-map reference model.
module tb_hyper_macro_cfg_resp;

    localparam int AW = 19;
    localparam int TS = 20;
    localparam logic [31:0] ID_VAL = 32'h4859_0001;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [31:0]   cfg_data_i = '0;
    logic [5:0]    cfg_addr_i = '0;
    logic          cfg_valid_i = 1'b0;
    logic          cfg_rwn_i = 1'b0;
    logic          cfg_ready_o;
    logic [31:0]   cfg_data_o;
    logic [AW-1:0] rx_startaddr_o, tx_startaddr_o;
    logic [TS-1:0] rx_size_o, tx_size_o;
    logic [1:0]    rx_datasize_o, tx_datasize_o;
    logic          rx_continuous_o, tx_continuous_o;
    logic          rx_req_o, rx_clr_o, tx_req_o, tx_clr_o;
    logic          rx_en_i = 0, rx_pending_i = 0, tx_en_i = 0, tx_pending_i = 0;
    logic [AW-1:0] rx_curr_addr_i = '0, tx_curr_addr_i = '0;
    logic [TS-1:0] rx_bytes_left_i = '0, tx_bytes_left_i = '0;

    hyper_macro_cfg_resp #(.AW(AW), .TS(TS), .ID_VAL(ID_VAL)) dut (
        .sys_clk_i(clk), .rst_i(rst),
        .cfg_data_i(cfg_data_i), .cfg_addr_i(cfg_addr_i),
        .cfg_valid_i(cfg_valid_i), .cfg_rwn_i(cfg_rwn_i),
        .cfg_ready_o(cfg_ready_o), .cfg_data_o(cfg_data_o),
        .rx_startaddr_o(rx_startaddr_o), .rx_size_o(rx_size_o),
        .rx_datasize_o(rx_datasize_o), .rx_continuous_o(rx_continuous_o),
        .rx_req_o(rx_req_o), .rx_clr_o(rx_clr_o),
        .rx_en_i(rx_en_i), .rx_pending_i(rx_pending_i),
        .rx_curr_addr_i(rx_curr_addr_i), .rx_bytes_left_i(rx_bytes_left_i),
        .tx_startaddr_o(tx_startaddr_o), .tx_size_o(tx_size_o),
        .tx_datasize_o(tx_datasize_o), .tx_continuous_o(tx_continuous_o),
        .tx_req_o(tx_req_o), .tx_clr_o(tx_clr_o),
        .tx_en_i(tx_en_i), .tx_pending_i(tx_pending_i),
        .tx_curr_addr_i(tx_curr_addr_i), .tx_bytes_left_i(tx_bytes_left_i)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    // Reference model state
    int unsigned m_sa[2], m_sz[2], m_ds[2], m_ct[2];
    int unsigned m_scratch;
    int unsigned e_req[2], e_clr[2];
    int unsigned n_req[2], n_clr[2];
    logic [31:0] exp_q[$];

    function automatic void model_reset();
        for (int c = 0; c < 2; c++) begin
            m_sa[c] = 0; m_sz[c] = 0; m_ds[c] = 0; m_ct[c] = 0;
        end
        m_scratch = 0;
    endfunction

    function automatic int unsigned st_en(int c);
        return (c == 0) ? int'(rx_en_i) : int'(tx_en_i);
    endfunction

    function automatic int unsigned st_pend(int c);
        return (c == 0) ? int'(rx_pending_i) : int'(tx_pending_i);
    endfunction

    function automatic logic [31:0] model_read(input int unsigned a);
        int c;
        c = (a >= 4) ? 1 : 0;
        if (a == 32'h20) return ID_VAL;
        if (a == 32'h21) return m_scratch;
        if (a >= 8 || a == 3 || a == 7) return 0;
        case (a % 4)
            0: return (c == 0) ? 32'(rx_curr_addr_i) : 32'(tx_curr_addr_i);
            1: return (c == 0) ? 32'(rx_bytes_left_i) : 32'(tx_bytes_left_i);
            default: return st_pend(c) * 32 + st_en(c) * 16
                            + m_ds[c] * 2 + m_ct[c];
        endcase
    endfunction

    function automatic void model_write(input int unsigned a,
                                        input int unsigned d);
        int c;
        c = (a >= 4) ? 1 : 0;
        if (a == 32'h21) m_scratch = d;
        if (a >= 8 || a == 3 || a == 7) return;
        case (a % 4)
            0: m_sa[c] = d % (1 << AW);
            1: m_sz[c] = d % (1 << TS);
            default: begin
                m_ct[c] = d % 2;
                m_ds[c] = (d / 2) % 4;
                if ((d / 64) % 2 == 1) e_clr[c]++;
                else if ((d / 16) % 2 == 1
                         && !(st_en(c) == 1 && st_pend(c) == 1)) e_req[c]++;
            end
        endcase
    endfunction

    // Response monitor and pulse counters
    always @(negedge clk) begin
        if (rx_req_o) n_req[0]++;
        if (tx_req_o) n_req[1]++;
        if (rx_clr_o) n_clr[0]++;
        if (tx_clr_o) n_clr[1]++;
        if (cfg_ready_o) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL resp_unexpected: got ready with %08h, none expected",
                         cfg_data_o);
            end else begin
                chk("resp_data", cfg_data_o, exp_q.pop_front());
            end
        end
    end

    task automatic check_state();
        chk("rx_startaddr", 32'(rx_startaddr_o), m_sa[0]);
        chk("rx_size", 32'(rx_size_o), m_sz[0]);
        chk("rx_cfg", 32'({rx_datasize_o, rx_continuous_o}), m_ds[0] * 2 + m_ct[0]);
        chk("tx_startaddr", 32'(tx_startaddr_o), m_sa[1]);
        chk("tx_size", 32'(tx_size_o), m_sz[1]);
        chk("tx_cfg", 32'({tx_datasize_o, tx_continuous_o}), m_ds[1] * 2 + m_ct[1]);
        chk("rx_req_pulses", n_req[0], e_req[0]);
        chk("rx_clr_pulses", n_clr[0], e_clr[0]);
        chk("tx_req_pulses", n_req[1], e_req[1]);
        chk("tx_clr_pulses", n_clr[1], e_clr[1]);
    endtask

    task automatic xact(input logic rwn, input logic [5:0] a,
                        input logic [31:0] d);
        bit got;
        if (rwn) exp_q.push_back(model_read(a));
        else begin
            exp_q.push_back(32'd0);
            model_write(a, d);
        end
        @(negedge clk);
        cfg_valid_i = 1'b1;
        cfg_rwn_i   = rwn;
        cfg_addr_i  = a;
        cfg_data_i  = d;
        got = 0;
        for (int i = 0; i < 8 && !got; i++) begin
            @(posedge clk);
            #1;
            if (cfg_ready_o) got = 1;
        end
        cfg_valid_i = 1'b0;
        if (!got) begin
            checks++;
            errors++;
            $display("FAIL ready_timeout: got no ready, required ready for addr %02h", a);
        end
        repeat (2) @(posedge clk);
        #1;
        check_state();
    endtask

    function automatic logic [5:0] pick_addr();
        logic [5:0] tbl [11];
        tbl = '{6'h00, 6'h01, 6'h02, 6'h03, 6'h04, 6'h05,
                6'h06, 6'h07, 6'h20, 6'h21, 6'h22};
        if ($urandom_range(0, 7) == 0) return 6'($urandom);
        return tbl[$urandom_range(0, 10)];
    endfunction

    initial begin
        bit r;
        model_reset();
        for (int c = 0; c < 2; c++) begin
            e_req[c] = 0; e_clr[c] = 0; n_req[c] = 0; n_clr[c] = 0;
        end
        repeat (3) @(posedge clk);
        #1;
        chk("reset_ready", 32'(cfg_ready_o), 0);
        chk("reset_data", cfg_data_o, 0);
        rst = 1'b0;
        check_state();

        // Basic RX programming and start
        xact(0, 6'h00, 32'h1234);
        xact(0, 6'h01, 32'h100);
        xact(0, 6'h02, 32'h13);
        chk("rx_startaddr_dir", 32'(rx_startaddr_o), 32'h1234);
        chk("rx_req_dir", n_req[0], 1);

        // Valid held five cycles: ready in cycles 2, 4 (and 6 from the third accept)
        repeat (3) exp_q.push_back(ID_VAL);
        @(posedge clk);
        #1;
        cfg_valid_i = 1'b1;
        cfg_rwn_i   = 1'b1;
        cfg_addr_i  = 6'h20;
        for (int k = 2; k <= 6; k++) begin
            @(posedge clk);
            #1;
            r = cfg_ready_o;
            if (k == 6) cfg_valid_i = 1'b0;
            chk($sformatf("held_ready_c%0d", k), 32'(r),
                (k == 2 || k == 4 || k == 6) ? 1 : 0);
        end
        repeat (2) @(posedge clk);
        #1;

        // EN+CLR on TX: clear only
        xact(0, 6'h06, 32'h50);
        chk("tx_clr_dir", n_clr[1], 1);
        chk("tx_req_dir", n_req[1], 0);

        // Start dropped while RX busy with a pending slot
        @(negedge clk);
        rx_en_i = 1;
        rx_pending_i = 1;
        xact(0, 6'h02, 32'h10);
        chk("rx_req_drop", n_req[0], 1);
        xact(1, 6'h02, 32'h0);
        rx_en_i = 0;
        rx_pending_i = 0;

        // Reset during RESP aborts the write
        xact(0, 6'h21, 32'hDEAD_BEEF);
        xact(1, 6'h21, 32'h0);
        exp_q.push_back(32'd0);
        @(negedge clk);
        cfg_valid_i = 1'b1;
        cfg_rwn_i   = 1'b0;
        cfg_addr_i  = 6'h02;
        cfg_data_i  = 32'h55;
        @(posedge clk);
        #1;
        chk("rst_resp_ready", 32'(cfg_ready_o), 1);
        rst = 1'b1;
        cfg_valid_i = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
        chk("rst_abort_ready", 32'(cfg_ready_o), 0);
        repeat (2) @(posedge clk);
        #1;
        check_state();
        xact(1, 6'h21, 32'h0);

        // Randomized traffic
        for (int n = 0; n < 300; n++) begin
            logic [5:0] a;
            @(negedge clk);
            rx_en_i = 1'($urandom);
            rx_pending_i = 1'($urandom);
            tx_en_i = 1'($urandom);
            tx_pending_i = 1'($urandom);
            rx_curr_addr_i = AW'($urandom);
            tx_curr_addr_i = AW'($urandom);
            rx_bytes_left_i = TS'($urandom);
            tx_bytes_left_i = TS'($urandom);
            a = pick_addr();
            xact(1'($urandom), a, $urandom);
        end

        repeat (3) @(posedge clk);
        chk("resp_queue_empty", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1);
    end

endmodule
